// File: rtl/mem_responder.sv
// -----------------------------------------------------------------------------
// mem_responder
//
// Burst memory responder that sits on the memory side of a cache. It holds a
// block of 32-bit words and serves whole cache lines as fixed-length bursts.
// A request is accepted in IDLE. The first beat follows after a programmable
// number of idle cycles. Each beat is flagged by ack, and the final beat also
// raises last.
//
// Parameters
//   ADDR_WIDTH : log2 of storage depth in 32-bit words
//   LATENCY    : idle cycles between request acceptance and first beat (0..15)
//   LINE_WORDS : beats per burst (power of two, 1..16)
//
// Ports
//   clk   : single clock, all state changes on the rising edge
//   rst   : synchronous active-high reset; storage is not cleared
//   cs    : request valid, held high by the requester until the last ack
//   we    : 1 = write burst, 0 = read burst
//   addr  : word address; the burst base is addr with the line offset cleared
//   din   : write data for the current beat
//   dout  : registered read data, valid while ack is high on a read burst
//   ack   : one beat transferred this cycle
//   last  : final beat of the burst
//   busy  : responder is not in IDLE
// -----------------------------------------------------------------------------
module mem_responder #(
    parameter int ADDR_WIDTH = 10,
    parameter int LATENCY    = 3,
    parameter int LINE_WORDS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cs,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] din,
    output logic [31:0] dout,
    output logic        ack,
    output logic        last,
    output logic        busy
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int OFF_W = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
    localparam logic [ADDR_WIDTH-1:0] LINE_MASK = ADDR_WIDTH'(LINE_WORDS - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_BURST,
        ST_DONE
    } state_t;

    state_t                  state_q, state_d;
    logic                    we_q, we_d;
    logic [ADDR_WIDTH-1:0]   base_q, base_d;
    logic [3:0]              cnt_q, cnt_d;
    logic [OFF_W-1:0]        idx_q, idx_d;
    logic [31:0]             dout_q;
    logic [31:0]             mem_q [DEPTH];

    logic [ADDR_WIDTH-1:0]   req_base;
    logic [ADDR_WIDTH-1:0]   wr_addr;
    logic [ADDR_WIDTH-1:0]   rd_addr;
    logic                    beat_last;
    logic                    rd_en;

    // Upper address bits are deliberately ignored: storage wraps.
    logic                    unused_addr_hi;
    assign unused_addr_hi = ^addr[31:ADDR_WIDTH];

    // Line base of an incoming request. The beat index is OR-ed into the
    // cleared offset bits, so it can never carry into the line number.
    assign req_base  = addr[ADDR_WIDTH-1:0] & ~LINE_MASK;
    assign wr_addr   = base_q | ADDR_WIDTH'(idx_q);
    assign beat_last = (idx_q == OFF_W'(LINE_WORDS - 1));

    // A beat is only transferred while the requester still holds cs. Dropping
    // cs in BURST therefore suppresses the ack in that same cycle. Reset
    // overrides everything, including a write that would land on this edge.
    assign ack  = (state_q == ST_BURST) && cs && !rst;
    assign last = ack && beat_last;
    assign busy = (state_q != ST_IDLE);
    assign dout = dout_q;

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        base_d  = base_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        case (state_q)
            ST_IDLE: begin
                if (cs) begin
                    we_d    = we;
                    base_d  = req_base;
                    cnt_d   = 4'(LATENCY);
                    idx_d   = '0;
                    state_d = (LATENCY == 0) ? ST_BURST : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (!cs) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        state_d = ST_BURST;
                        idx_d   = '0;
                    end
                end
            end
            ST_BURST: begin
                if (!cs) begin
                    state_d = ST_IDLE;
                    idx_d   = '0;
                end else if (beat_last) begin
                    state_d = ST_DONE;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + OFF_W'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Storage is read one cycle ahead. Whenever the next cycle is a read
    // beat, the word for that beat is fetched on this edge so that it is
    // already on dout during the ack cycle.
    assign rd_en   = (state_d == ST_BURST) && !we_d;
    assign rd_addr = base_d | ADDR_WIDTH'(idx_d);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            we_q    <= 1'b0;
            base_q  <= '0;
            cnt_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            base_q  <= base_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dout_q <= '0;
        end else if (rd_en) begin
            dout_q <= mem_q[rd_addr];
        end
    end

    // The storage array has no reset, so its contents survive rst.
    always_ff @(posedge clk) begin
        if (ack && we_q) begin
            mem_q[wr_addr] <= din;
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_mem_responder
//
// Self-checking bench for mem_responder. Two instances share the clock and
// reset. Instance 0 uses LATENCY=3 and instance 1 uses LATENCY=0; both use
// LINE_WORDS=4. Read expectations come from a bench-side storage model. They
// are queued when a read request is driven and popped on each expected ack
// beat. Inputs are driven 1 time unit after the rising edge, and outputs are
// sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_mem_responder;

    localparam int AW    = 10;
    localparam int DEPTH = 1 << AW;
    localparam int LW    = 4;
    localparam int LAT_A = 3;
    localparam int LAT_B = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst;
    logic [1:0]       cs_v;
    logic [1:0]       we_v;
    logic [1:0][31:0] addr_v;
    logic [1:0][31:0] din_v;
    logic [1:0][31:0] dout_v;
    logic [1:0]       ack_v;
    logic [1:0]       last_v;
    logic [1:0]       busy_v;

    mem_responder #(.ADDR_WIDTH(AW), .LATENCY(LAT_A), .LINE_WORDS(LW)) dut_a (
        .clk (clk),
        .rst (rst),
        .cs  (cs_v[0]),
        .we  (we_v[0]),
        .addr(addr_v[0]),
        .din (din_v[0]),
        .dout(dout_v[0]),
        .ack (ack_v[0]),
        .last(last_v[0]),
        .busy(busy_v[0])
    );

    mem_responder #(.ADDR_WIDTH(AW), .LATENCY(LAT_B), .LINE_WORDS(LW)) dut_b (
        .clk (clk),
        .rst (rst),
        .cs  (cs_v[1]),
        .we  (we_v[1]),
        .addr(addr_v[1]),
        .din (din_v[1]),
        .dout(dout_v[1]),
        .ack (ack_v[1]),
        .last(last_v[1]),
        .busy(busy_v[1])
    );

    int          n_checks = 0;
    int          n_errs   = 0;
    logic [31:0] model_a [DEPTH];
    logic [31:0] model_b [DEPTH];
    logic [31:0] exp_q0 [$];
    logic [31:0] exp_q1 [$];
    logic [31:0] wdat [LW];
    int          beat_cnt [2];
    logic [31:0] beat_base [2];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Compare one cycle of instance d against the expected handshake. On an
    // expected beat, either record the write in the model or pop the next
    // expected read word.
    task automatic sample(input int d, input bit e_ack, input bit e_last,
                          input bit e_busy, input string tag);
        logic [31:0] exp_w;
        logic [AW-1:0] wa;
        check_val({tag, " ack"},  {31'b0, ack_v[d]},  {31'b0, e_ack});
        check_val({tag, " last"}, {31'b0, last_v[d]}, {31'b0, e_last});
        check_val({tag, " busy"}, {31'b0, busy_v[d]}, {31'b0, e_busy});
        if (e_ack) begin
            wa = AW'(beat_base[d] + 32'(beat_cnt[d] % LW));
            if (we_v[d]) begin
                if (d == 0) model_a[wa] = din_v[d];
                else        model_b[wa] = din_v[d];
            end else begin
                if (d == 0) begin
                    if (exp_q0.size() == 0) check_val({tag, " sb_empty"}, 32'd0, 32'd1);
                    else begin exp_w = exp_q0.pop_front(); check_val({tag, " dout"}, dout_v[d], exp_w); end
                end else begin
                    if (exp_q1.size() == 0) check_val({tag, " sb_empty"}, 32'd0, 32'd1);
                    else begin exp_w = exp_q1.pop_front(); check_val({tag, " dout"}, dout_v[d], exp_w); end
                end
            end
            $display("beat %s dut=%0d idx=%0d we=%0b addr=%h dout=%h din=%h", tag, d,
                     beat_cnt[d] % LW, we_v[d], beat_base[d] + 32'(beat_cnt[d] % LW),
                     dout_v[d], din_v[d]);
            beat_cnt[d]++;
        end
    endtask

    // One burst starting from IDLE. The request is presented in cycle k=0.
    // abort_after < 0 runs the full line. Otherwise cs drops in the cycle
    // after that many acks. addr is scrambled after acceptance.
    task automatic do_burst(input int d, input int lat, input logic wr,
                            input logic [31:0] a, input int abort_after, input string tag);
        int nbeats, cs_end;
        logic [31:0] base;
        base   = a & ~32'(LW - 1);
        nbeats = (abort_after < 0) ? LW : abort_after;
        cs_end = lat + nbeats;
        beat_base[d] = base;
        beat_cnt[d]  = 0;
        if (!wr) begin
            for (int i = 0; i < nbeats; i++) begin
                if (d == 0) exp_q0.push_back(model_a[AW'(base + 32'(i))]);
                else        exp_q1.push_back(model_b[AW'(base + 32'(i))]);
            end
        end
        for (int k = 0; k <= cs_end + 2; k++) begin
            @(posedge clk); #1;
            cs_v[d]   = (k <= cs_end);
            we_v[d]   = wr;
            addr_v[d] = (k == 0) ? a : $urandom;
            din_v[d]  = wdat[beat_cnt[d] % LW];
            @(negedge clk);
            sample(d, (k >= lat + 1) && (k <= lat + nbeats),
                   (abort_after < 0) && (k == lat + LW),
                   (k >= 1) && (k <= cs_end + 1), tag);
        end
    endtask

    initial begin
        rst    = 1'b1;
        cs_v   = 2'b11;
        we_v   = 2'b00;
        addr_v = '0;
        din_v  = '0;

        // Reset held two edges while cs is high, then one cycle with rst low.
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            if (k == 2) rst = 1'b0;
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                check_val("rst ack",  {31'b0, ack_v[d]},  32'd0);
                check_val("rst last", {31'b0, last_v[d]}, 32'd0);
                check_val("rst busy", {31'b0, busy_v[d]}, 32'd0);
                check_val("rst dout", dout_v[d], 32'd0);
            end
        end
        // Let the requests accepted in that last cycle abort cleanly.
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            cs_v = 2'b00;
        end

        // Preload line 0x40, then read it back from mid-line address 0x41.
        wdat = '{32'h11, 32'h22, 32'h33, 32'h44};
        do_burst(0, LAT_A, 1'b1, 32'h40, -1, "a_pre40");
        do_burst(0, LAT_A, 1'b0, 32'h41, -1, "a_rd41");

        // Write burst, then read back.
        wdat = '{32'hA0, 32'hA1, 32'hA2, 32'hA3};
        do_burst(0, LAT_A, 1'b1, 32'h80, -1, "a_wr80");
        do_burst(0, LAT_A, 1'b0, 32'h80, -1, "a_rd80");

        // Aborted write after two beats: only the first two words change.
        wdat = '{32'h55, 32'h56, 32'h57, 32'h58};
        do_burst(0, LAT_A, 1'b1, 32'h100, -1, "a_pre100");
        wdat = '{32'hC0, 32'hC1, 32'hC2, 32'hC3};
        do_burst(0, LAT_A, 1'b1, 32'h100, 2, "a_abort");
        do_burst(0, LAT_A, 1'b0, 32'h100, -1, "a_rd100");

        // Reset in the second WAIT cycle of a read: no ack ever.
        beat_base[0] = 32'h80;
        beat_cnt[0]  = 0;
        for (int k = 0; k <= 10; k++) begin
            @(posedge clk); #1;
            cs_v[0]   = (k <= 2);
            we_v[0]   = 1'b0;
            addr_v[0] = 32'h80;
            rst       = (k == 2);
            @(negedge clk);
            sample(0, 1'b0, 1'b0, (k >= 1) && (k <= 2), "a_rstwait");
        end
        do_burst(0, LAT_A, 1'b0, 32'h80, -1, "a_rd80b");

        // High address bits ignored: 0xFFFFFC42 wraps onto line 0x040.
        do_burst(0, LAT_A, 1'b0, 32'hFFFF_FC42, -1, "a_wrap");

        // LATENCY=0 instance: preload, then two back-to-back reads.
        wdat = '{32'hB0, 32'hB1, 32'hB2, 32'hB3};
        do_burst(1, LAT_B, 1'b1, 32'h0, -1, "b_wr0");
        beat_base[1] = 32'h0;
        beat_cnt[1]  = 0;
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < LW; i++) exp_q1.push_back(model_b[AW'(i)]);
        for (int k = 0; k <= 12; k++) begin
            @(posedge clk); #1;
            cs_v[1]   = (k <= 10);
            we_v[1]   = 1'b0;
            addr_v[1] = (k == 0 || k == 6) ? 32'h0 : $urandom;
            @(negedge clk);
            sample(1, (k >= 1 && k <= 4) || (k >= 7 && k <= 10),
                   (k == 4) || (k == 10),
                   (k >= 1 && k <= 5) || (k >= 7 && k <= 11), "b_b2b");
        end

        check_val("sb0 drained", 32'(exp_q0.size()), 32'd0);
        check_val("sb1 drained", 32'(exp_q1.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
        $finish;
    end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 10, log2 of storage depth in 32-bit words.
REQ-002 SHALL have parameter LATENCY, default 3, idle cycles between request acceptance and first data beat (legal 0..15).
REQ-003 SHALL have parameter LINE_WORDS, default 4, beats per burst (power of two, 1..16).
REQ-004 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-005 SHALL have port rst  input  1  synchronous active-high reset.
REQ-006 SHALL have port cs  input  1  request valid from the cache side; held high until the last ack.
REQ-007 SHALL have port we  input  1  1 = write burst, 0 = read burst; stable while cs high.
REQ-008 SHALL have port addr  input  32  word address; burst base = addr with low log2(LINE_WORDS) bits cleared.
REQ-009 SHALL have port din  input  32  write data for the current beat; requester advances it after each ack.
REQ-010 SHALL have port dout  output  32  registered read data, valid while ack high on a read burst.
REQ-011 SHALL have port ack  output  1  one beat transferred this cycle.
REQ-012 SHALL have port last  output  1  high with the final ack of a burst.
REQ-013 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-014 SHALL implement FSM states IDLE, WAIT, BURST, DONE.
REQ-015 IDLE: cs sampled high latches we and burst base and loads the latency counter; next state is WAIT, or BURST when LATENCY=0.
REQ-016 WAIT: counter decrements each cycle; at 1, next state is BURST; ack held low.
REQ-017 BURST: ack high for LINE_WORDS consecutive cycles; beat index increments 0..LINE_WORDS-1; word address = base + index.
REQ-018 The first ack SHALL occur in cycle T+1+LATENCY, where T is the cycle in which cs is first sampled high in IDLE.
REQ-019 Read beat: dout SHALL present mem[base+index] in the ack cycle (storage read one cycle ahead); dout holds its last value otherwise.
REQ-020 Write beat: mem[base+index] SHALL be written with din on the clock edge ending each ack cycle.
REQ-021 last SHALL be high only with ack on beat LINE_WORDS-1; next state after it is DONE.
REQ-022 DONE: one cycle, ack low, busy high; next state IDLE; a cs still high is treated as a new request in that IDLE cycle.
REQ-023 Abort: cs sampled low in WAIT or BURST SHALL send the FSM to IDLE on the next edge with no ack in the following cycle; beats already written remain.
REQ-024 Address bits above ADDR_WIDTH SHALL be ignored (storage wraps modulo 2^ADDR_WIDTH); the index never carries into bits above the line offset.
REQ-025 Changes to we or addr while busy SHALL have no effect on the burst in progress.

Reset
REQ-026 On rst high at a clock edge: state IDLE, ack=0, last=0, busy=0, dout=0, counters=0, regardless of current state.
REQ-027 Reset SHALL NOT clear storage contents.
REQ-028 rst SHALL take priority over any cs activity in the same cycle.

Verification
REQ-029 Reset: rst high 2 cycles with cs=1 -> ack=0, last=0, busy=0, dout=0 through the cycle after rst falls, excluding any new request.
REQ-030 Read burst (LATENCY=3, LINE_WORDS=4): preload mem[0x40..0x43]=0x11,0x22,0x33,0x44; cs=1, we=0, addr=0x41 in cycle 0 -> ack in cycles 4-7, dout 0x11,0x22,0x33,0x44, last only in cycle 7, busy low in cycle 9.
REQ-031 Write burst: addr=0x80, we=1, din 0xA0,0xA1,0xA2,0xA3 advanced on each ack -> subsequent read of 0x80 returns 0xA0..0xA3 in order.
REQ-032 Abort: write burst to 0x100 with cs dropped after the second ack -> no ack the next cycle, busy=0 the cycle after, mem[0x100..0x101] written, mem[0x102..0x103] unchanged.
REQ-033 Reset mid-WAIT: rst pulsed in cycle 2 of a read request -> no ack ever issued, busy=0 the cycle after rst, storage unchanged.
REQ-034 Back-to-back with LATENCY=0: cs held high across two read bursts -> acks cycles 1-4, DONE cycle 5 (ack=0), second burst acks cycles 7-10.
